// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator. Free-running h/v counters give
// a request coordinate; sync/de/strobe bits derived from that coordinate
// are delayed PIPE cycles so that a pipelined pixel source can return the
// colour in time. Narrow input colour is widened by MSB replication.
//
// Ports:
//   vgaclk            pixel clock
//   rst               synchronous active-high reset
//   in_r/in_g/in_b    colour for the pixel requested PIPE-1 cycles earlier
//   pattern_en        select built-in colour-bar pattern (macro build only)
//   req_x/req_y       request coordinate (raw counters)
//   req_valid         request coordinate lies in the active area
//   hsync/vsync/de    delayed timing outputs
//   frame_start       one-cycle pulse at output pixel (0,0)
//   line_start        one-cycle pulse at output pixel x=0 of every line
//   red/green/blue    output colour, zero outside active video
//
// Build option: define VGA_TIMING_TEST_PATTERN_EN to include the 8-bar
// test pattern; otherwise pattern_en is ignored.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = 10,
  parameter int   IN_R     = 3,
  parameter int   IN_G     = 3,
  parameter int   IN_B     = 2,
  parameter int   OUT_W    = 4,
  parameter int   PIPE     = 2
) (
  input  logic             vgaclk,
  input  logic             rst,
  input  logic [IN_R-1:0]  in_r,
  input  logic [IN_G-1:0]  in_g,
  input  logic [IN_B-1:0]  in_b,
  input  logic             pattern_en,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  output logic             req_valid,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start,
  output logic             line_start,
  output logic [OUT_W-1:0] red,
  output logic [OUT_W-1:0] green,
  output logic [OUT_W-1:0] blue
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW1   = CNT_W + 1;

  // Boundaries are held one bit wider than the counters: the sync end can
  // equal the total length, which may not fit in CNT_W bits.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W:0]   H_ACT_X  = CW1'(H_ACTIVE);
  localparam logic [CNT_W:0]   HS_BEG_X = CW1'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0]   HS_END_X = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0]   V_ACT_X  = CW1'(V_ACTIVE);
  localparam logic [CNT_W:0]   VS_BEG_X = CW1'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0]   VS_END_X = CW1'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if ((64'd1 << CNT_W) < 64'(H_TOT) || (64'd1 << CNT_W) < 64'(V_TOT)) begin : g_err_cnt
      $error("vga_timing_gen: CNT_W too small for line/frame length");
    end
    if (PIPE < 1 || PIPE > 8) begin : g_err_pipe
      $error("vga_timing_gen: PIPE must be within 1..8");
    end
    if (IN_R < 1 || IN_R > OUT_W || IN_G < 1 || IN_G > OUT_W ||
        IN_B < 1 || IN_B > OUT_W) begin : g_err_width
      $error("vga_timing_gen: input colour widths must be within 1..OUT_W");
    end
  endgenerate

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic ls;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0, fs: 1'b0, ls: 1'b0};

  // ---------------- raster counters ----------------
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (rst) begin
      hc_d = '0;
      vc_d = '0;
    end else if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
    end else begin
      hc_d = hc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge vgaclk) begin
    hc_q <= hc_d;
    vc_q <= vc_d;
  end

  // ---------------- timing decode at request time ----------------
  logic [CNT_W:0] hc_x, vc_x;
  logic           h_act, v_act;
  ctl_t           ctl_src;

  assign hc_x  = {1'b0, hc_q};
  assign vc_x  = {1'b0, vc_q};
  assign h_act = hc_x < H_ACT_X;
  assign v_act = vc_x < V_ACT_X;

  always_comb begin
    ctl_src.hs = (hc_x >= HS_BEG_X && hc_x < HS_END_X) ? HS_POL : ~HS_POL;
    ctl_src.vs = (vc_x >= VS_BEG_X && vc_x < VS_END_X) ? VS_POL : ~VS_POL;
    ctl_src.de = h_act && v_act;
    ctl_src.fs = (hc_q == '0) && (vc_q == '0);
    ctl_src.ls = (hc_q == '0);
  end

  assign req_x     = hc_q;
  assign req_y     = vc_q;
  assign req_valid = h_act && v_act;

  // ---------------- control delay line ----------------
  // Stage PIPE-1 is the output register; ctl_d[PIPE-1] is what enters it,
  // which also decides whether the colour sampled on that edge is gated.
  ctl_t ctl_q [PIPE];
  ctl_t ctl_d [PIPE];

  always_comb begin
    ctl_d[0] = rst ? CTL_IDLE : ctl_src;
    for (int i = 1; i < PIPE; i++) begin
      ctl_d[i] = rst ? CTL_IDLE : ctl_q[i-1];
    end
  end

  always_ff @(posedge vgaclk) begin
    for (int i = 0; i < PIPE; i++) begin
      ctl_q[i] <= ctl_d[i];
    end
  end

  assign hsync       = ctl_q[PIPE-1].hs;
  assign vsync       = ctl_q[PIPE-1].vs;
  assign de          = ctl_q[PIPE-1].de;
  assign frame_start = ctl_q[PIPE-1].fs;
  assign line_start  = ctl_q[PIPE-1].ls;

  // ---------------- colour widening ----------------
  // Output bit k (from the MSB) takes input bit (k mod W) from the MSB, so
  // the input pattern repeats until the output width is filled.
  logic [OUT_W-1:0] red_exp, green_exp, blue_exp;

  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_exp
      assign red_exp[OUT_W-1-gi]   = in_r[IN_R-1-(gi % IN_R)];
      assign green_exp[OUT_W-1-gi] = in_g[IN_G-1-(gi % IN_G)];
      assign blue_exp[OUT_W-1-gi]  = in_b[IN_B-1-(gi % IN_B)];
    end
  endgenerate

  logic [OUT_W-1:0] red_src, green_src, blue_src;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'((H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1);

  // x of the pixel whose control bits are entering the output stage.
  logic [CNT_W-1:0] x_late;
  logic [CNT_W-1:0] bar_idx;
  logic             unused_bar_hi;

  generate
    if (PIPE == 1) begin : g_xdly_none
      assign x_late = hc_q;
    end else begin : g_xdly
      logic [CNT_W-1:0] x_q [PIPE-1];
      logic [CNT_W-1:0] x_d [PIPE-1];

      always_comb begin
        x_d[0] = rst ? '0 : hc_q;
        for (int i = 1; i < PIPE - 1; i++) begin
          x_d[i] = rst ? '0 : x_q[i-1];
        end
      end

      always_ff @(posedge vgaclk) begin
        for (int i = 0; i < PIPE - 1; i++) begin
          x_q[i] <= x_d[i];
        end
      end

      assign x_late = x_q[PIPE-2];
    end
  endgenerate

  assign bar_idx       = x_late / BAR_W;
  assign unused_bar_hi = ^(bar_idx >> 3);

  assign red_src   = pattern_en ? {OUT_W{bar_idx[2]}} : red_exp;
  assign green_src = pattern_en ? {OUT_W{bar_idx[1]}} : green_exp;
  assign blue_src  = pattern_en ? {OUT_W{bar_idx[0]}} : blue_exp;
`else
  logic unused_pattern_en;
  assign unused_pattern_en = pattern_en;

  assign red_src   = red_exp;
  assign green_src = green_exp;
  assign blue_src  = blue_exp;
`endif

  // ---------------- colour output register ----------------
  logic [OUT_W-1:0] red_q, red_d;
  logic [OUT_W-1:0] green_q, green_d;
  logic [OUT_W-1:0] blue_q, blue_d;

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (!rst && ctl_d[PIPE-1].de) begin
      red_d   = red_src;
      green_d = green_src;
      blue_d  = blue_src;
    end
  end

  always_ff @(posedge vgaclk) begin
    red_q   <= red_d;
    green_q <= green_d;
    blue_q  <= blue_d;
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule
